// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue
//   Decoupled instruction fetch front end. Issues sequential ROM fetches ahead
//   of decode into a DEPTH-entry in-order queue. Multiple fetches may be in
//   flight against a variable-latency ROM. A redirect (flush) empties the queue
//   and arranges for responses to already-issued fetches to be dropped.
// Ports
//   clk, rst            clock; synchronous active-low reset
//   o_romEnable/o_romAddr/i_romReady   fetch request handshake
//   i_romValid/i_romInst               in-order ROM responses
//   i_flush/i_flushPc                  redirect to a new PC (low 2 bits ignored)
//   i_stall                            downstream holds the head entry
//   o_instValid/o_inst/o_pc            head of queue (registered, no bypass)
module inst_prefetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_romEnable,
  output logic [ADDR_W-1:0] o_romAddr,
  input  logic              i_romReady,
  input  logic              i_romValid,
  input  logic [INST_W-1:0] i_romInst,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_flushPc,
  input  logic              i_stall,
  output logic              o_instValid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic [DEPTH-1:0][INST_W-1:0] mem;
  logic [ADDR_W-1:0] fetch_pc, head_pc, flush_tgt;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, outstanding, discard;
  logic [OCC_W-1:0]  occ;
  logic              accept, rsp, drop, push, pop;

  // Queued plus in-flight never exceeds DEPTH, so a response always has a slot.
  assign occ         = OCC_W'(count) + OCC_W'(outstanding);
  assign o_romEnable = rst & ~i_flush & (occ < DEPTH_C);
  assign o_romAddr   = fetch_pc;
  assign accept      = o_romEnable & i_romReady;

  // A response with nothing outstanding is a ROM protocol error and is ignored.
  assign rsp  = rst & i_romValid & (outstanding != '0);
  assign drop = rsp & (discard != '0);
  assign push = rsp & ~drop & ~i_flush;

  assign o_instValid = rst & (count != '0);
  assign pop         = o_instValid & ~i_stall & ~i_flush;
  assign o_inst      = rst ? mem[rd_ptr] : '0;
  assign o_pc        = head_pc;

  assign flush_tgt = i_flushPc & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_romInst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (i_flush) begin
      fetch_pc    <= flush_tgt;
      head_pc     <= flush_tgt;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CNT_W'(rsp);
      // outstanding already covers responses owed from earlier flushes, so
      // everything still in flight after this cycle belongs to a dead stream.
      discard     <= outstanding - CNT_W'(rsp);
    end else begin
      if (accept) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (push)   wr_ptr   <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        head_pc <= head_pc + ADDR_W'(4);
      end
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp);
      discard     <= discard - CNT_W'(drop);
    end
  end

endmodule
